protocol_encoder: RTL and testbench

- Transmit side of the team's serial framing protocol; the receiving end is the existing protocol decoder.
- Accepts one byte at a time over a valid/ready handshake and serialises it on a single line.
- Frame: start pair (0 then 1), 8 data bits MSB first, one parity bit, then an idle-high gap.
- Parity bit = 1 XOR (XOR of the 8 data bits), i.e. odd parity over data+parity.
- Sits between a byte-producing core and the serial link feeding a decoder.

---
 rtl/protocol_encoder.sv | 179 +++++++++++++++++
 tb/tb_protocol_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_encoder.sv
// protocol_encoder: byte-to-serial framer (start 0/1, 8 data bits MSB first, odd parity, idle-high gap).
// Optional feature macro: PROTOCOL_ENCODER_ERR_INJECT_EN adds err_inject to corrupt one frame's parity.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, tx_ready high, waiting for a byte
// S_START_LO | first start half, line low
// S_START_HI | second start half, line high
// S_DATA   | shifting out 8 data bits, MSB first
// S_PARITY | parity bit (odd parity, optionally inverted)
// S_GAP    | forced idle-high gap, frame_done on exit
module protocol_encoder #(
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_BITS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
`ifdef PROTOCOL_ENCODER_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(IDLE_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START_LO = 3'd1;
    localparam logic [2:0] S_START_HI = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_PARITY   = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    // The decoder needs at least one idle bit after parity to resynchronise.
    if (IDLE_BITS < 1) begin : g_idle_bits_chk
        $error("protocol_encoder: IDLE_BITS must be >= 1");
    end
    if (CLKS_PER_BIT < 1) begin : g_clks_chk
        $error("protocol_encoder: CLKS_PER_BIT must be >= 1");
    end

    logic [2:0]    state, state_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic [GW-1:0] gap_cnt, gap_cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic          par, par_d;
    logic          so_d, done_d, busy_d;
    logic          inj;
    logic          bit_end;

`ifdef PROTOCOL_ENCODER_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    assign tx_ready = (state == S_IDLE);
    assign bit_end  = (bit_cnt == '0);

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        gap_cnt_d = gap_cnt;
        idx_d     = idx;
        shift_d   = shift;
        par_d     = par;
        done_d    = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    par_d     = ~(^tx_data) ^ inj;
                    bit_cnt_d = BIT_RELOAD;
                    state_d   = S_START_LO;
                end
            end
            S_START_LO: begin
                if (bit_end) begin
                    bit_cnt_d = BIT_RELOAD;
                    state_d   = S_START_HI;
                end else begin
                    bit_cnt_d = bit_cnt - CW'(1);
                end
            end
            S_START_HI: begin
                if (bit_end) begin
                    bit_cnt_d = BIT_RELOAD;
                    idx_d     = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = BIT_RELOAD;
                    shift_d   = {shift[6:0], 1'b0};
                    idx_d     = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end else begin
                    bit_cnt_d = bit_cnt - CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = BIT_RELOAD;
                    gap_cnt_d = GAP_RELOAD;
                    state_d   = S_GAP;
                end else begin
                    bit_cnt_d = bit_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    bit_cnt_d = BIT_RELOAD;
                    if (gap_cnt == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt - GW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so it registers alongside it.
    always_comb begin
        so_d = 1'b1;
        case (state_d)
            S_START_LO: so_d = 1'b0;
            S_DATA:     so_d = shift_d[7];
            S_PARITY:   so_d = par_d;
            default:    so_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            idx        <= 3'd0;
            shift      <= 8'h00;
            par        <= 1'b0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            idx        <= idx_d;
            shift      <= shift_d;
            par        <= par_d;
            serial_out <= so_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_protocol_encoder.sv
// Bench for protocol_encoder: two instances (1 and 4 clocks per bit) with a scoreboard-fed line decoder.
`timescale 1ns/1ps
module tb_protocol_encoder;
    localparam int IB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data0, data1;
    logic       valid0, valid1, inj0, inj1;
    logic       rdy0, rdy1, so0, so1, busy0, busy1, done0, done1;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];
    int acc_cyc[2];
    int st_last[2];
    int st_prev[2];
    int n_abort[2];
    int n_frames[2];
    int n_done[2];
    bit in_frame[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done0 === 1'b1) n_done[0]++;
        if (done1 === 1'b1) n_done[1]++;
    end

    protocol_encoder #(.CLKS_PER_BIT(1), .IDLE_BITS(IB)) u_dut_c1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (data0),
        .tx_valid   (valid0),
`ifdef PROTOCOL_ENCODER_ERR_INJECT_EN
        .err_inject (inj0),
`endif
        .tx_ready   (rdy0),
        .serial_out (so0),
        .busy       (busy0),
        .frame_done (done0)
    );

    protocol_encoder #(.CLKS_PER_BIT(4), .IDLE_BITS(IB)) u_dut_c4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (data1),
        .tx_valid   (valid1),
`ifdef PROTOCOL_ENCODER_ERR_INJECT_EN
        .err_inject (inj1),
`endif
        .tx_ready   (rdy1),
        .serial_out (so1),
        .busy       (busy1),
        .frame_done (done1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic so_of(input int d);
        return (d == 0) ? so0 : so1;
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    // Drive one byte, push its expected frame when the handshake completes.
    task automatic send(input int d, input logic [7:0] b, input logic inj, input bit keep);
        int n;
        logic [9:0] e;
        n = 0;
        @(negedge clk);
        while (rdy_of(d) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait", n < 1000, 1);
        if (d == 0) begin data0 = b; valid0 = 1'b1; inj0 = inj; end
        else        begin data1 = b; valid1 = 1'b1; inj1 = inj; end
        @(posedge clk);
        #1;
        e = {inj, 1'b1 ^ (^b) ^ inj, b};
        if (d == 0) exp0.push_back(e);
        else        exp1.push_back(e);
        acc_cyc[d] = cyc;
        if (d == 0) begin data0 = ~b; inj0 = 1'b0; if (!keep) valid0 = 1'b0; end
        else        begin data1 = ~b; inj1 = 1'b0; if (!keep) valid1 = 1'b0; end
    endtask

    // Line decoder: checks every cycle of a frame against the popped expectation.
    task automatic monitor(input int d, input int cpb);
        int len, errs, nbusy, sz, k;
        bit ab;
        logic [9:0] e;
        logic [7:0] rx;
        logic rxp, perr;
        logic bits [0:10+IB];
        len = (11 + IB) * cpb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && so_of(d) === 1'b0) begin
                in_frame[d] = 1'b1;
                st_prev[d] = st_last[d];
                st_last[d] = cyc;
                chk("start_latency", cyc - acc_cyc[d], 0);
                sz = (d == 0) ? exp0.size() : exp1.size();
                e = '0;
                if (sz == 0) chk("frame_expected", sz, 1);
                else if (d == 0) e = exp0.pop_front();
                else e = exp1.pop_front();
                bits[0] = 1'b0;
                bits[1] = 1'b1;
                for (int i = 0; i < 8; i++) bits[2+i] = e[7-i];
                bits[10] = e[8];
                for (int i = 0; i < IB; i++) bits[11+i] = 1'b1;
                errs = 0; nbusy = 0; ab = 0; rx = 8'h00; rxp = 1'b0;
                for (int j = 0; j < len; j++) begin
                    if (j > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin ab = 1; break; end
                    if (so_of(d) !== bits[j / cpb]) errs++;
                    if (busy_of(d) === 1'b1) nbusy++;
                    if (done_of(d) !== 1'b0) errs++;
                    if (j % cpb == cpb / 2) begin
                        k = j / cpb;
                        if (k >= 2 && k <= 9) rx = {rx[6:0], so_of(d)};
                        if (k == 10) rxp = so_of(d);
                    end
                end
                if (ab) begin
                    n_abort[d]++;
                end else begin
                    perr = ~((^rx) ^ rxp);
                    chk("line_errs", errs, 0);
                    chk("busy_cycles", nbusy, len);
                    chk("rx_data", rx, e[7:0]);
                    chk("rx_parity_err", perr, e[9]);
                    @(negedge clk);
                    if (rst_n === 1'b1) begin
                        chk("frame_done", done_of(d), 1);
                        chk("ready_after", rdy_of(d), 1);
                        chk("busy_after", busy_of(d), 0);
                        n_frames[d]++;
                    end
                end
                in_frame[d] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (n < 2000 && (in_frame[d] || ((d == 0) ? exp0.size() : exp1.size()) != 0)) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", n < 2000, 1);
        repeat (2) @(negedge clk);
    endtask

    initial monitor(0, 1);
    initial monitor(1, 4);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, d0, nf;
        rst_n = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; inj0 = 1'b0; inj1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_so", so0, 1);
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        d0 = n_done[0]; bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (so0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("idle_line", bad, 0);
        chk("idle_done_pulses", n_done[0] - d0, 0);

        send(0, 8'hA5, 1'b0, 1'b0);
        wait_idle(0);

        send(0, 8'h01, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b0);
        wait_idle(0);
        chk("b2b_start_gap", st_last[0] - st_prev[0], 14);

        send(1, 8'h00, 1'b0, 1'b0);
        wait_idle(1);

        send(0, 8'hC3, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_bit", so0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_so", so0, 1);
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_ready", rdy0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("aborted", n_abort[0], 1);
        send(0, 8'h3C, 1'b0, 1'b0);
        wait_idle(0);
        nf = 4;
`ifdef PROTOCOL_ENCODER_ERR_INJECT_EN
        send(0, 8'hA5, 1'b1, 1'b0);
        wait_idle(0);
        nf = 5;
`endif
        chk("frames_c1", n_frames[0], nf);
        chk("frames_c4", n_frames[1], 1);
        chk("done_pulses_c1", n_done[0], nf);
        chk("done_pulses_c4", n_done[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
